// File: rtl/pipe_latch_pkg.sv
// Shared definitions for the generic inter-stage pipeline latch:
// run modes, step-control states and o_debug field offsets.
package pipe_latch_pkg;

    localparam logic [1:0] CONT_MODE = 2'b01;
    localparam logic [1:0] STEP_MODE = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STEP_IDLE,
        ST_STEP_PENDING,
        ST_HALTED
    } step_state_t;

    // o_debug layout, LSB first:
    // data, ctrl, valid, eof, step_pending, halted, adv_count
    localparam int DBG_DATA_LSB = 0;

    function automatic int dbg_ctrl_lsb(int nb_data);
        return nb_data;
    endfunction

    function automatic int dbg_valid_bit(int nb_data, int nb_ctrl);
        return nb_data + nb_ctrl;
    endfunction

    function automatic int dbg_eof_bit(int nb_data, int nb_ctrl);
        return nb_data + nb_ctrl + 1;
    endfunction

    function automatic int dbg_pend_bit(int nb_data, int nb_ctrl);
        return nb_data + nb_ctrl + 2;
    endfunction

    function automatic int dbg_halt_bit(int nb_data, int nb_ctrl);
        return nb_data + nb_ctrl + 3;
    endfunction

    function automatic int dbg_cnt_lsb(int nb_data, int nb_ctrl);
        return nb_data + nb_ctrl + 4;
    endfunction

endpackage

// File: rtl/step_ctrl_fsm.sv
// Step-request edge detection and run/step/halt state machine
// deciding when the pipeline latch may advance.
module step_ctrl_fsm
    import pipe_latch_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_pipeline_mode,
    input  logic       i_execute_instruct,
    input  logic       i_stall,
    input  logic       i_flush,
    input  logic       i_valid,
    input  logic       i_EOF_flag,
    output logic       o_adv_req,
    output logic       o_step_pending,
    output logic       o_halted
);

    step_state_t state;
    step_state_t state_next;
    logic        exec_q;
    logic        step_edge;
    logic        advance;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_RUN;
            exec_q <= 1'b0;
        end else begin
            state  <= state_next;
            exec_q <= i_execute_instruct;
        end
    end

    always_comb begin
        step_edge  = i_execute_instruct & ~exec_q;
        o_adv_req  = 1'b0;
        state_next = state;

        // Request follows the live mode so a hold takes effect at once
        if (state != ST_HALTED) begin
            case (i_pipeline_mode)
                CONT_MODE: o_adv_req = 1'b1;
                STEP_MODE: o_adv_req = (state == ST_STEP_PENDING);
                default:   o_adv_req = 1'b0;
            endcase
        end

        advance = o_adv_req & ~i_stall & ~i_flush;

        if (state == ST_HALTED) begin
            state_next = ST_HALTED;
        end else if (advance & i_valid & i_EOF_flag) begin
            state_next = ST_HALTED;
        end else begin
            case (i_pipeline_mode)
                CONT_MODE: state_next = ST_RUN;
                STEP_MODE: begin
                    if (state == ST_STEP_PENDING)
                        state_next = advance ? ST_STEP_IDLE
                                             : ST_STEP_PENDING;
                    else
                        state_next = step_edge ? ST_STEP_PENDING
                                               : ST_STEP_IDLE;
                end
                default:   state_next = ST_STEP_IDLE;
            endcase
        end

        o_step_pending = (state == ST_STEP_PENDING);
        o_halted       = (state == ST_HALTED);
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage pipeline register with stall, flush, single-step,
// halt-on-EOF and debug snapshot. Optional PIPE_STAGE_LATCH_PERF_EN counters.
module pipe_stage_latch
    import pipe_latch_pkg::*;
#(
    parameter int NB_CTRL  = 9,
    parameter int NB_DATA  = 140,
    parameter int NB_CNT   = 16,
    parameter int DBG_SIZE = NB_DATA + NB_CTRL + NB_CNT + 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [1:0]          i_pipeline_mode,
    input  logic                i_execute_instruct,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_CTRL-1:0]  i_ctrl,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_EOF_flag,
    output logic                o_valid,
    output logic [NB_CTRL-1:0]  o_ctrl,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_EOF_flag,
    output logic                o_halted,
    output logic                o_step_pending,
    output logic [NB_CNT-1:0]   o_adv_count,
    output logic [DBG_SIZE-1:0] o_debug
`ifdef PIPE_STAGE_LATCH_PERF_EN
    ,
    output logic [NB_CNT-1:0]   o_stall_count,
    output logic [NB_CNT-1:0]   o_bubble_count
`endif
);

    logic adv_req;
    logic advance;

    step_ctrl_fsm u_step_ctrl (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_pipeline_mode    (i_pipeline_mode),
        .i_execute_instruct (i_execute_instruct),
        .i_stall            (i_stall),
        .i_flush            (i_flush),
        .i_valid            (i_valid),
        .i_EOF_flag         (i_EOF_flag),
        .o_adv_req          (adv_req),
        .o_step_pending     (o_step_pending),
        .o_halted           (o_halted)
    );

    // adv_req is already low once halted
    assign advance = adv_req & ~i_stall & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_ctrl      <= '0;
            o_data      <= '0;
            o_EOF_flag  <= 1'b0;
            o_adv_count <= '0;
        end else if (!o_halted) begin
            if (i_flush) begin
                o_valid    <= 1'b0;
                o_ctrl     <= '0;
                o_EOF_flag <= 1'b0;
            end else if (advance) begin
                o_valid     <= i_valid;
                o_ctrl      <= i_valid ? i_ctrl : '0;
                o_data      <= i_data;
                o_EOF_flag  <= i_EOF_flag;
                o_adv_count <= o_adv_count + 1'b1;
            end
        end
    end

    assign o_debug = {o_adv_count, o_halted, o_step_pending,
                      o_EOF_flag, o_valid, o_ctrl, o_data};

`ifdef PIPE_STAGE_LATCH_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_count  <= '0;
            o_bubble_count <= '0;
        end else begin
            if (adv_req & i_stall & ~o_halted)
                o_stall_count <= o_stall_count + 1'b1;
            if ((i_flush & ~o_halted) | (advance & ~i_valid))
                o_bubble_count <= o_bubble_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Generic parametrised inter-stage pipeline register, successor to the fixed-field ID/EX latch; one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control vector, a payload vector, a valid bit and the EOF flag.
- Adds stall (hold), flush (bubble insertion), edge-triggered single-step with a pending token, halt-on-EOF, an advance counter and a packed debug snapshot for the debug unit.

Parameters:
- NB_CTRL, 9, control-bit vector width
- NB_DATA, 140, payload width (PC, operands, immediates, register fields concatenated by the instantiating stage)
- NB_CNT, 16, advance-counter width
- DBG_SIZE, NB_DATA+NB_CTRL+NB_CNT+4, debug snapshot width (derived; do not override)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  synchronous reset, active-high
- i_pipeline_mode  in  2  01 = continuous, 11 = stepwise, other = hold
- i_execute_instruct  in  1  step request level from the debug unit; rising edge = one step
- i_stall  in  1  hazard-unit hold request
- i_flush  in  1  insert bubble (branch/jump squash)
- i_valid  in  1  upstream entry valid
- i_ctrl  in  NB_CTRL  upstream control bits
- i_data  in  NB_DATA  upstream payload
- i_EOF_flag  in  1  upstream end-of-program marker
- o_valid  out  1  latched valid
- o_ctrl  out  NB_CTRL  latched control bits
- o_data  out  NB_DATA  latched payload
- o_EOF_flag  out  1  latched EOF
- o_halted  out  1  stage halted after EOF
- o_step_pending  out  1  step token waiting for an advance
- o_adv_count  out  NB_CNT  number of advances since reset
- o_debug  out  DBG_SIZE  packed snapshot {o_adv_count, o_halted, o_step_pending, o_EOF_flag, o_valid, o_ctrl, o_data}; LSB = o_data[0]

Behaviour:
- Reset: single clock, reset synchronous and active-high as above. Every output and register clears to 0; state = ST_RUN; registered step-request history = 0.
- Step edge: step_edge = i_execute_instruct & ~exec_q, where exec_q is i_execute_instruct registered every cycle.
- State machine:
  - ST_RUN: active when mode = 01. adv_req = 1 every cycle.
  - ST_STEP_IDLE: mode = 11, no token. step_edge → ST_STEP_PENDING.
  - ST_STEP_PENDING: adv_req = 1. On an actual advance → ST_STEP_IDLE. Further step edges while pending are dropped; there is no queue deeper than 1.
  - ST_HALTED: entered on any advance or flush that latches o_valid = 1 with EOF = 1. Left only by reset.
  - Mode changes are evaluated each cycle from any non-halted state:
    - 01 → ST_RUN
    - 11 → ST_STEP_IDLE, or ST_STEP_PENDING if step_edge is high the same cycle
    - other → ST_STEP_IDLE with adv_req = 0; the pending token is discarded
- Priority per cycle: reset > halted > flush > stall > advance > hold.
  - Halted: all data outputs frozen; i_flush, i_stall and steps ignored.
  - Flush: o_valid ← 0, o_ctrl ← 0, o_EOF_flag ← 0, o_data unchanged. Does not count as an advance. Applied in every mode, including hold. A pending step token is retained.
  - Stall with adv_req: all outputs held; the step token stays pending.
  - Advance (adv_req & ~stall & ~flush & ~halted): o_valid/o_ctrl/o_data/o_EOF_flag ← inputs; o_adv_count increments, wrapping 2^NB_CNT−1 → 0.
  - If i_valid = 0 on an advance, o_ctrl is forced to 0 (bubble), while o_data and o_EOF_flag are still captured.
- Latency: 1 cycle from input to output on an advance. o_halted asserts the cycle after the EOF entry is latched. o_step_pending asserts the cycle after step_edge.
- o_debug is combinational from the registered outputs; it adds no extra latency.

Optional Feature:
- Macro PIPE_STAGE_LATCH_PERF_EN.
- When defined: adds ports o_stall_count and o_bubble_count, each NB_CNT wide, wrapping, cleared by reset.
  - o_stall_count increments each cycle where adv_req & i_stall & ~halted.
  - o_bubble_count increments on each flush, and on each advance with i_valid = 0.
- When undefined: ports and counters are absent; DBG_SIZE and o_debug layout are unchanged.

Decomposition:
- Package pipe_latch_pkg holds:
  - mode constants CONT_MODE = 2'b01 and STEP_MODE = 2'b11
  - state enum (ST_RUN, ST_STEP_IDLE, ST_STEP_PENDING, ST_HALTED)
  - the o_debug field-offset localparams, so the debug unit unpacks with the same offsets
- One sub-module, step_ctrl_fsm: edge detect plus state machine, producing adv_req, o_step_pending and o_halted. The datapath register and counters stay in the top level.

Test Plan:
- Continuous mode: mode = 01, stream i_ctrl = 9'h0A5 and i_data = 5 for one cycle, valid = 1 → o_ctrl = 9'h0A5 and o_data = 5 one cycle later; o_adv_count = 1.
- Stall then flush: hold i_stall high for 3 cycles → outputs unchanged and count unchanged; then i_flush with i_stall still high → o_valid = 0, o_ctrl = 0, o_data retained, count unchanged.
- Step mode:
  - Hold i_execute_instruct high for 5 cycles → exactly one advance (count +1).
  - Two edges 2 cycles apart while stalled → one pending token only; releasing the stall yields a single advance.
- EOF halt: advance with i_valid = 1 and EOF = 1 → o_halted = 1 next cycle; later inputs, flush and steps change nothing; i_reset clears everything to 0 the next edge.
- Counter wrap and reset: NB_CNT = 4, 17 continuous advances → o_adv_count = 1. Assert i_reset for 1 cycle mid-stream → all outputs 0 on the next edge; a reset asserted while a step is pending drops the token.
